// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// The master drives operands and accepts results. The slave is the adder.
interface cla_addsub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_overflow;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_overflow
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_overflow
   );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined signed add/sub built from 4-bit CLA groups, STAGES register stages, valid/ready flow.
// Define SATURATE_EN to clamp out_result on signed overflow (last stage, no added latency).
module cla_addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input logic              clk,
   input logic              rst,
   cla_addsub_pipe_if.slave bus
);
   localparam int G = WIDTH / (4 * STAGES);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] take;
   logic [WIDTH-1:0]  b_eff;

   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      p    = a ^ b;
      g    = a & b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;

   // A stage may load when it, or any stage between it and the output, is empty,
   // or when the output is being accepted: the same as !v[k] | take[k+1], unrolled.
   always_comb begin
      logic        all_full;
      int unsigned idx;
      all_full = 1'b1;
      take     = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         idx       = STAGES - 1 - i;
         all_full  = all_full & v[idx];
         take[idx] = bus.out_ready | ~all_full;
      end
   end

   assign bus.in_ready  = take[0];
   assign bus.out_valid = v[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
      end else begin
         if (take[0]) v[0] <= bus.in_valid;
         for (int unsigned k = 1; k < STAGES; k++)
            if (take[k]) v[k] <= v[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int BASE = k * G * 4;
      localparam int TOP  = BASE + G * 4;

      logic [WIDTH-1:BASE] sa;
      logic [WIDTH-1:BASE] sb;
      logic [TOP-1:0]      sum;
      logic [G*4-1:0]      gs;
      logic                c_in;
      logic                gc;
      logic                v_in;
      logic                en;

      if (k == 0) begin : src
         assign sa   = bus.in_a;
         assign sb   = b_eff;
         assign c_in = bus.in_sub;
         assign sum  = gs;
         assign v_in = bus.in_valid;
      end else begin : src
         assign sa   = stg[k-1].nxt.a_r;
         assign sb   = stg[k-1].nxt.b_r;
         assign c_in = stg[k-1].nxt.c_r;
         assign sum  = {gs, stg[k-1].nxt.s_r};
         assign v_in = v[k-1];
      end

      assign en = take[k] & v_in;

      always_comb begin
         gc = c_in;
         gs = '0;
         for (int unsigned j = 0; j < G; j++)
            {gc, gs[j*4 +: 4]} = cla4(sa[BASE + j*4 +: 4], sb[BASE + j*4 +: 4], gc);
      end

      if (k == STAGES - 1) begin : nxt
         logic             ovf_d;
         logic [WIDTH-1:0] res_d;
         logic [WIDTH-1:0] res_r;
         logic             c_r;
         logic             ovf_r;

         assign ovf_d = (sa[WIDTH-1] == sb[WIDTH-1]) & (sum[WIDTH-1] != sa[WIDTH-1]);
`ifdef SATURATE_EN
         assign res_d = ovf_d ? {sa[WIDTH-1], {(WIDTH-1){~sa[WIDTH-1]}}} : sum;
`else
         assign res_d = sum;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_r <= '0;
               c_r   <= 1'b0;
               ovf_r <= 1'b0;
            end else if (en) begin
               res_r <= res_d;
               c_r   <= gc;
               ovf_r <= ovf_d;
            end
         end

         assign bus.out_result   = res_r;
         assign bus.out_carry    = c_r;
         assign bus.out_overflow = ovf_r;
      end else begin : nxt
         // Only operand bits not yet consumed travel on; resolved sum bits accumulate.
         logic [WIDTH-1:TOP] a_r;
         logic [WIDTH-1:TOP] b_r;
         logic [TOP-1:0]     s_r;
         logic               c_r;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_r <= '0;
               b_r <= '0;
               s_r <= '0;
               c_r <= 1'b0;
            end else if (en) begin
               a_r <= sa[WIDTH-1:TOP];
               b_r <= sb[WIDTH-1:TOP];
               s_r <= sum;
               c_r <= gc;
            end
         end
      end
   end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed cases on 16/2 plus random sweeps on 16/2, 32/4 and 8/1.
// Expected values come from a signed-integer reference model.
module tb_cla_addsub_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cla_addsub_pipe_if #(.WIDTH(16)) b16 ();
   cla_addsub_pipe_if #(.WIDTH(32)) b32 ();
   cla_addsub_pipe_if #(.WIDTH(8))  b8  ();

   cla_addsub_pipe #(.WIDTH(16), .STAGES(2)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   cla_addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   cla_addsub_pipe #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(b8));

   typedef struct packed {
      logic [63:0] res;
      logic        c;
      logic        o;
   } exp_t;

   function automatic exp_t ref_op(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit sub);
      exp_t              e;
      longint unsigned   m;
      longint            sa, sb, ex, hi, lo;
      m  = (64'd1 << w) - 64'd1;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      sa = a[w-1] ? longint'(a) - longint'(m) - 1 : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(m) - 1 : longint'(b);
      ex = sub ? sa - sb : sa + sb;
      e.c = sub ? (a >= b) : ((a + b) > m);
      e.o = (ex > hi) || (ex < lo);
`ifdef SATURATE_EN
      if (ex > hi) ex = hi;
      else if (ex < lo) ex = lo;
`endif
      e.res = ex & m;
      return e;
   endfunction

   function automatic longint unsigned rnd_operand(input int w);
      longint unsigned m;
      m = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0:       return m >> 1;
         1:       return (m >> 1) + 64'd1;
         2:       return 64'd0;
         3:       return m;
         4:       return 64'd1;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output logic [15:0] r, output logic c, output logic o, output int lat);
      int n;
      b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b16.in_valid = 1'b1;
      b16.in_a = a;
      b16.in_b = b;
      b16.in_sub = sub;
      n = 0;
      do begin @(negedge clk); n++; end while (!b16.in_ready && n < 20);
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!b16.out_valid && lat < 20);
      r = b16.out_result;
      c = b16.out_carry;
      o = b16.out_overflow;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({b16.out_valid, b16.out_result, b16.out_carry, b16.out_overflow} !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b r=%h c=%b o=%b exp all 0", b16.out_valid,
                  b16.out_result, b16.out_carry, b16.out_overflow);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (b16.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", b16.in_ready);
      end
   endtask

   task automatic test_case(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [15:0] er, input logic ec, input logic eo);
      logic [15:0] r;
      logic        c, o;
      int          lat;
      do_op(a, b, sub, r, c, o, lat);
      checks += 4;
      if (r !== er) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, r, er); end
      if (c !== ec) begin failures++; $display("FAIL %s_carry got=%b exp=%b", name, c, ec); end
      if (o !== eo) begin failures++; $display("FAIL %s_ovf got=%b exp=%b", name, o, eo); end
      if (lat != 2) begin failures++; $display("FAIL %s_latency got=%0d exp=2", name, lat); end
   endtask

   task automatic test_add();
      test_case("add", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
   endtask

   task automatic test_sub();
      test_case("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      test_case("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
`ifdef SATURATE_EN
      test_case("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      test_case("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      test_case("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      test_case("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
   endtask

   task automatic test_backpressure();
      logic [15:0] oa[4], ob[4];
      logic        os[4];
      exp_t        q[$];
      exp_t        e;
      int          acc, got;
      for (int i = 0; i < 4; i++) begin
         oa[i] = 16'($urandom);
         ob[i] = 16'($urandom);
         os[i] = 1'($urandom_range(0, 1));
      end
      acc = 0;
      got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(posedge clk); #1;
         b16.out_ready = (c >= 5);
         b16.in_valid  = (acc < 4);
         if (acc < 4) begin
            b16.in_a = oa[acc];
            b16.in_b = ob[acc];
            b16.in_sub = os[acc];
         end
         @(negedge clk);
         if (acc == 2 && !b16.out_ready) begin
            checks++;
            if (b16.in_ready !== 1'b0) begin
               failures++;
               $display("FAIL bp_in_ready got=%b exp=0 cycle=%0d", b16.in_ready, c);
            end
         end
         if (b16.out_valid && !b16.out_ready) begin
            checks++;
            if (q.size() == 0 || {b16.out_result, b16.out_carry, b16.out_overflow} !==
                                 {q[0].res[15:0], q[0].c, q[0].o}) begin
               failures++;
               $display("FAIL bp_held got=%h/%b/%b exp=%h/%b/%b", b16.out_result, b16.out_carry,
                        b16.out_overflow, q.size() ? q[0].res[15:0] : 16'h0,
                        q.size() ? q[0].c : 1'b0, q.size() ? q[0].o : 1'b0);
            end
         end
         if (b16.in_valid && b16.in_ready) begin
            q.push_back(ref_op(16, 64'(b16.in_a), 64'(b16.in_b), b16.in_sub));
            acc++;
         end
         if (b16.out_valid && b16.out_ready) begin
            checks++;
            got++;
            e = q.size() ? q.pop_front() : '0;
            if ({b16.out_result, b16.out_carry, b16.out_overflow} !== {e.res[15:0], e.c, e.o}) begin
               failures++;
               $display("FAIL bp_order item=%0d got=%h/%b/%b exp=%h/%b/%b", got, b16.out_result,
                        b16.out_carry, b16.out_overflow, e.res[15:0], e.c, e.o);
            end
         end
      end
      b16.in_valid = 1'b0;
      checks++;
      if (got != 4 || acc != 4) begin
         failures++;
         $display("FAIL bp_count got=%0d accepted=%0d exp=4/4", got, acc);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (b16.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_duplicate out_valid=%b exp=0", b16.out_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int k, n;
      k = 0;
      n = 0;
      b16.out_ready = 1'b0;
      while (k < 2 && n < 10) begin
         @(posedge clk); #1;
         b16.in_valid = 1'b1;
         b16.in_a = 16'($urandom);
         b16.in_b = 16'($urandom);
         b16.in_sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (b16.in_ready) k++;
         n++;
      end
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({b16.out_valid, b16.out_result, b16.out_carry, b16.out_overflow} !== 19'd0) begin
         failures++;
         $display("FAIL rst_mid_outputs got v=%b r=%h c=%b o=%b exp all 0", b16.out_valid,
                  b16.out_result, b16.out_carry, b16.out_overflow);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      b16.out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (b16.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stale out_valid=%b exp=0", b16.out_valid);
         end
      end
      test_case("rst_fresh", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0);
   endtask

   // Random traffic; exact latency is required for items that saw no stall since acceptance.
`define RANDOM_SWEEP(TNAME, BUS, W, S, NOPS, LBL) \
   task automatic TNAME(); \
      exp_t q[$]; \
      int   qc[$]; \
      exp_t e; \
      int   sent, got, lat, last_stall, ent; \
      bit   acc; \
      sent = 0; got = 0; last_stall = -1; acc = 1'b0; \
      BUS.in_valid = 1'b0; \
      for (int n = 0; n < (NOPS) * 8 + 100 && got < (NOPS); n++) begin \
         @(posedge clk); #1; \
         if (!BUS.in_valid || acc) begin \
            acc = 1'b0; \
            BUS.in_valid = (sent < (NOPS)) && ($urandom_range(0, 3) != 0); \
            BUS.in_a = W'(rnd_operand(W)); \
            BUS.in_b = W'(rnd_operand(W)); \
            BUS.in_sub = 1'($urandom_range(0, 1)); \
         end \
         BUS.out_ready = (sent < (NOPS) / 2) || ($urandom_range(0, 2) != 0); \
         @(negedge clk); \
         if (!BUS.out_ready) last_stall = cyc; \
         if (BUS.in_valid && BUS.in_ready) begin \
            q.push_back(ref_op(W, 64'(BUS.in_a), 64'(BUS.in_b), BUS.in_sub)); \
            qc.push_back(cyc); \
            sent++; \
            acc = 1'b1; \
         end \
         if (BUS.out_valid && BUS.out_ready) begin \
            got++; \
            checks++; \
            if (q.size() == 0) begin \
               failures++; \
               $display("FAIL %s_spurious got=%h exp=none", LBL, BUS.out_result); \
            end else begin \
               e = q.pop_front(); \
               ent = qc.pop_front(); \
               lat = cyc - ent; \
               if ({64'(BUS.out_result), BUS.out_carry, BUS.out_overflow} !== {e.res, e.c, e.o}) begin \
                  failures++; \
                  $display("FAIL %s_data item=%0d got=%h/%b/%b exp=%h/%b/%b", LBL, got, \
                           BUS.out_result, BUS.out_carry, BUS.out_overflow, W'(e.res), e.c, e.o); \
               end \
               checks++; \
               if ((ent > last_stall) ? (lat != (S)) : (lat < (S))) begin \
                  failures++; \
                  $display("FAIL %s_latency item=%0d got=%0d exp=%0d", LBL, got, lat, S); \
               end \
            end \
         end \
      end \
      BUS.in_valid = 1'b0; \
      checks++; \
      if (got != (NOPS) || q.size() != 0) begin \
         failures++; \
         $display("FAIL %s_count got=%0d exp=%0d pending=%0d", LBL, got, NOPS, q.size()); \
      end \
   endtask

   `RANDOM_SWEEP(test_random_w16, b16, 16, 2, 2000, "rand16")
   `RANDOM_SWEEP(test_sweep_w32, b32, 32, 4, 10000, "sweep32")
   `RANDOM_SWEEP(test_sweep_w8, b8, 8, 1, 10000, "sweep8")

   initial begin
      b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_sub = 1'b0; b16.out_ready = 1'b0;
      b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_sub = 1'b0; b32.out_ready = 1'b0;
      b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_sub  = 1'b0; b8.out_ready  = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_midstream();
      test_random_w16();
      test_sweep_w32();
      test_sweep_w8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
